hwpe_stream_tcdm_rr_arbiter: RTL
================================

// Module: hwpe_stream_tcdm_rr_arbiter
// PURPOSE
//  Shares one TCDM master port among NB_IN TCDM requesters using round-robin arbitration.
//  Returns each r_valid/r_data to the requester that issued the transaction, in issue order,
//  using an internal ID FIFO, so the downstream port may have multi-cycle latency.
//  Sits between HWPE streamers (source/sink address generators) and the cluster TCDM interconnect.
// PARAMETERS
//  NB_IN            4   number of requester ports (>=2)
//  MAX_OUTSTANDING  4   ID FIFO depth = max accepted but not-yet-responded transactions (>=1, power of 2)
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            synchronous reset, active-high
//  in_req_i       in   NB_IN        per-requester req
//  in_gnt_o       out  NB_IN        per-requester gnt
//  in_add_i       in   NB_IN*32     per-requester byte address
//  in_wen_i       in   NB_IN        1 = read, 0 = write
//  in_be_i        in   NB_IN*4      byte enables
//  in_data_i      in   NB_IN*32     write data
//  in_r_data_o    out  NB_IN*32     read data, out_r_data_i broadcast to all requesters
//  in_r_valid_o   out  NB_IN        response valid, one-hot or zero
//  out_req_o      out  1            shared port req
//  out_gnt_i      in   1            shared port gnt
//  out_add_o / out_wen_o / out_be_o / out_data_o  out  32/1/4/32  muxed from the winner
//  out_r_data_i   in   32           shared port read data
//  out_r_valid_i  in   1            shared port response valid, one per accepted req, in order
//  outstanding_o  out  $clog2(MAX_OUTSTANDING)+1   current ID FIFO occupancy
//  err_o          out  1            sticky: out_r_valid_i arrived with the ID FIFO empty
// BEHAVIOUR
//  - Reset: ptr=0, FIFO empty, outstanding_o=0, err_o=0, all in_gnt_o=0, out_req_o=0, in_r_valid_o=0.
//  - Request path is combinational, with zero latency.
//    - winner = first i with in_req_i[i]=1, scanning ptr, ptr+1, ... mod NB_IN.
//    - out_req_o = |in_req_i & !full; out_add/wen/be/data = winner fields (0 when none).
//    - in_gnt_o[winner] = out_gnt_i & !full; all other in_gnt_o=0.
//  - Handshake: accepted when out_req_o & out_gnt_i.
//    - On accept: push winner index into the FIFO, and ptr <= (winner+1) mod NB_IN.
//    - With no accept, ptr holds. A requester that keeps req high while not granted is eventually served within NB_IN accepts.
//  - Full: when outstanding_o == MAX_OUTSTANDING, out_req_o=0 and no gnt is issued, even if a pop occurs in the same cycle.
//    This keeps no path from r_valid to req.
//  - Response path is combinational.
//    - in_r_valid_o[head] = out_r_valid_i & !empty.
//    - On out_r_valid_i & !empty, pop the FIFO.
//    - Writes (wen=0) also get an r_valid, and also consume an entry.
//  - Empty: out_r_valid_i with the FIFO empty is dropped (no in_r_valid_o). err_o <= 1 and stays 1 until reset.
//  - Same-cycle push and pop: occupancy is unchanged. The pop returns the older head; the push is written behind it.
//    - If the FIFO was empty, the push cannot be popped in the same cycle (the response arrives >=1 cycle after accept).
//  - Counter: outstanding_o += accept - pop; it never exceeds MAX_OUTSTANDING and never goes below 0.
//  - Reset mid-operation: FIFO, ptr and err are cleared. Responses in flight after reset count as the empty case (err_o=1).
//    The surrounding system must drain or reset the TCDM side together with this block.
//  - Request inputs are not registered; requesters must hold req and fields stable until gnt (TCDM rule).
// TESTING
//  1. All 4 requesters hold req with out_gnt_i=1 and 1-cycle r_valid latency -> grants go to 0,1,2,3,0,...
//     Each r_valid reaches the issuing port, and r_data=0xA0+i matches.
//  2. Only port 2 requests, 10 back-to-back accesses -> port 2 is granted every cycle, and ptr reads 3 after each.
//  3. out_r_valid_i held 0, all ports request -> exactly 4 grants, then out_req_o=0 and outstanding_o=4.
//     One r_valid resumes grants on the next cycle.
//  4. Mixed write (port 1) and read (port 3) with 3-cycle latency -> in_r_valid_o[1] then in_r_valid_o[3], in order.
//     outstanding_o goes 1,2,...,0.
//  5. out_r_valid_i pulse with the FIFO empty -> no in_r_valid_o, err_o=1 and sticky; rst_i clears it.
//  6. Assert rst_i with 3 outstanding -> the next cycle has outstanding_o=0, ptr=0 and port 0 wins a 4-way tie.

Source files
------------

// File: rtl/hwpe_stream_tcdm_rr_arbiter.sv
// hwpe_stream_tcdm_rr_arbiter: round-robin share of one TCDM port among NB_IN requesters,
// with an ID FIFO that routes in-order responses back to their issuers.
module hwpe_stream_tcdm_rr_arbiter #(
   parameter int NB_IN           = 4,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic [NB_IN-1:0]                       in_req_i,
   output logic [NB_IN-1:0]                       in_gnt_o,
   input  logic [NB_IN*32-1:0]                    in_add_i,
   input  logic [NB_IN-1:0]                       in_wen_i,
   input  logic [NB_IN*4-1:0]                     in_be_i,
   input  logic [NB_IN*32-1:0]                    in_data_i,
   output logic [NB_IN*32-1:0]                    in_r_data_o,
   output logic [NB_IN-1:0]                       in_r_valid_o,
   output logic                                   out_req_o,
   input  logic                                   out_gnt_i,
   output logic [31:0]                            out_add_o,
   output logic                                   out_wen_o,
   output logic [3:0]                             out_be_o,
   output logic [31:0]                            out_data_o,
   input  logic [31:0]                            out_r_data_i,
   input  logic                                   out_r_valid_i,
   output logic [$clog2(MAX_OUTSTANDING):0]       outstanding_o,
   output logic                                   err_o
);
   localparam int IW = $clog2(NB_IN);
   localparam int AW = MAX_OUTSTANDING > 1 ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
   logic [IW-1:0] ptr, win;
   logic          any, full, empty, accept, pop;
   logic [IW-1:0] fifo [MAX_OUTSTANDING];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] cnt;
   int            j;
   // Scan from the highest offset down so the first requester after ptr wins.
   always_comb begin
      win = '0;
      any = 1'b0;
      j   = 0;
      for (int k = NB_IN - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= NB_IN) j = j - NB_IN;
         if (in_req_i[j]) begin
            win = IW'(j);
            any = 1'b1;
         end
      end
   end
   assign full          = cnt == CW'(MAX_OUTSTANDING);
   assign empty         = cnt == '0;
   assign out_req_o     = any & ~full;
   assign accept        = out_req_o & out_gnt_i;
   assign pop           = out_r_valid_i & ~empty;
   assign out_add_o     = any ? in_add_i[32*win +: 32] : '0;
   assign out_wen_o     = any ? in_wen_i[win] : 1'b0;
   assign out_be_o      = any ? in_be_i[4*win +: 4] : '0;
   assign out_data_o    = any ? in_data_i[32*win +: 32] : '0;
   assign in_gnt_o      = accept ? NB_IN'(1) << win : '0;
   assign in_r_valid_o  = pop ? NB_IN'(1) << fifo[rd_ptr] : '0;
   assign in_r_data_o   = {NB_IN{out_r_data_i}};
   assign outstanding_o = cnt;
   always_ff @(posedge clk_i) begin
      if (accept) fifo[wr_ptr] <= win;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
         err_o  <= 1'b0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr == AW'(MAX_OUTSTANDING - 1) ? '0 : wr_ptr + 1'b1;
            ptr    <= win == IW'(NB_IN - 1) ? '0 : win + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr == AW'(MAX_OUTSTANDING - 1) ? '0 : rd_ptr + 1'b1;
         if (out_r_valid_i & empty) err_o <= 1'b1;
         cnt <= cnt + CW'(accept) - CW'(pop);
      end
   end
endmodule
